// File: rtl/valve_table_driver.sv
// valve_table_driver: looks up a state address in a loadable table of trained
// valve settings, then slews valve_out toward that target in bounded steps and
// pulses valve_valid once the target is reached.
module valve_table_driver #(
  parameter int ADDR_W     = 9,
  parameter int VALVE_W    = 6,
  parameter int STEP_MAX   = 4,
  parameter int HOLD_CYC   = 8,
  parameter int SAFE_VALVE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic               addr_valid,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [VALVE_W-1:0] load_data,
  output logic               load_ready,
  output logic [VALVE_W-1:0] valve_out,
  output logic               valve_valid,
  output logic               busy,
  output logic               addr_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0]   CNT_RLD = CNT_W'(HOLD_CYC - 1);
  localparam logic [VALVE_W-1:0] SAFE    = VALVE_W'(SAFE_VALVE);
  localparam logic [VALVE_W-1:0] STEP_V  = VALVE_W'(STEP_MAX);
  localparam logic [VALVE_W:0]   STEP_W  = (VALVE_W + 1)'(STEP_MAX);

  typedef enum logic [1:0] {IDLE, LOOKUP, SLEW, DONE} state_t;

  state_t             state_q, state_d;
  logic [VALVE_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   wr_q;
  logic [VALVE_W-1:0] rd_q;
  logic               hit_q, bad_q;
  logic [VALVE_W-1:0] target_q, target_d;
  logic [VALVE_W-1:0] valve_q, valve_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [VALVE_W:0]   diff;
  logic               load_acc, look_acc;

  // A well-formed address has every 3-bit field in 1..3.
  function automatic logic malformed(input logic [ADDR_W-1:0] a);
    malformed = 1'b0;
    for (int i = 0; i < ADDR_W / 3; i++)
      if (a[3*i +: 3] == 3'd0 || a[3*i +: 3] > 3'd3) malformed = 1'b1;
  endfunction

  // Loads win over lookups; both only land while idle.
  assign load_acc = (state_q == IDLE) && load_en;
  assign look_acc = (state_q == IDLE) && !load_en && addr_valid;

  // Distance to target, widened one bit so it never wraps.
  assign diff = (target_q >= valve_q) ? ({1'b0, target_q} - {1'b0, valve_q})
                                      : ({1'b0, valve_q} - {1'b0, target_q});

  // Table data: no reset, registered read launched at the accept edge.
  always_ff @(posedge clk) begin
    if (load_acc) mem[load_addr] <= load_data;
    if (look_acc) rd_q <= mem[addr_in];
  end

  // Written bits and per-lookup address qualifiers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      hit_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      if (load_acc) wr_q[load_addr] <= 1'b1;
      if (look_acc) begin
        hit_q <= wr_q[addr_in];
        bad_q <= malformed(addr_in);
      end
    end
  end

  // Control and datapath state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= SAFE;
      valve_q  <= SAFE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      valve_q  <= valve_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Next state: resolve target in LOOKUP, then one bounded step per hold period;
  // DONE follows the cycle in which valve_out already equals the target.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    valve_d  = valve_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: if (look_acc) state_d = LOOKUP;
      LOOKUP: begin
        target_d = (bad_q || !hit_q) ? SAFE : rd_q;
        err_d    = err_q | bad_q;
        cnt_d    = CNT_RLD;
        state_d  = SLEW;
      end
      SLEW: begin
        if (valve_q == target_q) begin
          state_d = DONE;
        end else if (cnt_q == '0) begin
          cnt_d = CNT_RLD;
          if (diff <= STEP_W)           valve_d = target_q;
          else if (target_q > valve_q)  valve_d = valve_q + STEP_V;
          else                          valve_d = valve_q - STEP_V;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign load_ready  = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign valve_valid = (state_q == DONE);
  assign valve_out   = valve_q;
  assign addr_err    = err_q;

endmodule

// File: tb/tb_valve_table_driver.sv
// Bench for valve_table_driver: a reference table plus a slew model push the
// expected valve_out sequence into a queue; the monitor loop pops and compares.
module tb_valve_table_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] addr_in = '0;
  logic       addr_valid = 1'b0;
  logic       load_en = 1'b0;
  logic [8:0] load_addr = '0;
  logic [5:0] load_data = '0;
  logic       load_ready, valve_valid, busy, addr_err;
  logic [5:0] valve_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] m_mem [512];
  bit         m_wr  [512];
  logic [5:0] m_valve = 6'd0;
  bit         m_err = 1'b0;
  logic [5:0] exp_q [$];

  always #5 clk = ~clk;

  valve_table_driver dut (
    .clk(clk), .rst_n(rst_n),
    .addr_in(addr_in), .addr_valid(addr_valid),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready), .valve_out(valve_out), .valve_valid(valve_valid),
    .busy(busy), .addr_err(addr_err)
  );

  function automatic bit is_bad(input logic [8:0] a);
    return !((a[8:6] inside {[3'd1:3'd3]}) && (a[5:3] inside {[3'd1:3'd3]}) &&
             (a[2:0] inside {[3'd1:3'd3]}));
  endfunction

  task automatic load(input logic [8:0] a, input logic [5:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    m_mem[a] = d; m_wr[a] = 1'b1;
  endtask

  // Full lookup: predict step sequence and latency, then watch the DUT.
  task automatic run_lookup(input logic [8:0] a, input bit disturb, input string nm);
    logic [5:0] tgt, v, last, e;
    int n, lat, j;
    bit seen;
    tgt = (is_bad(a) || !m_wr[a]) ? 6'd0 : m_mem[a];
    v = m_valve;
    exp_q.delete();
    while (v != tgt) begin
      if (v < tgt) v = ((tgt - v) <= 6'd4) ? tgt : v + 6'd4;
      else         v = ((v - tgt) <= 6'd4) ? tgt : v - 6'd4;
      exp_q.push_back(v);
    end
    n = exp_q.size();
    lat = 2 + n * 8;
    if (is_bad(a)) m_err = 1'b1;
    @(negedge clk);
    addr_in = a; addr_valid = 1'b1;
    @(posedge clk); #1;
    addr_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || load_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s accept: busy=%b load_ready=%b, want 1/0", nm, busy, load_ready);
    end
    last = valve_out; j = 0; seen = 1'b0;
    for (int k = 1; k <= lat + 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (disturb && n > 0) begin
        if (k >= 4 && k <= 6) begin
          n_cmp++;
          if (load_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy_ignore k=%0d: load_ready=%b busy=%b, want 0/1",
                     nm, k, load_ready, busy);
          end
        end
        if (k == 3) begin
          addr_valid = 1'b1; addr_in = 9'o111;
          load_en = 1'b1; load_addr = a; load_data = 6'd63;
        end else if (k == 6) begin
          addr_valid = 1'b0; load_en = 1'b0;
        end
      end
      if (valve_out !== last) begin
        j++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s step: unexpected valve_out=%0d at k=%0d", nm, valve_out, k);
        end else begin
          e = exp_q.pop_front();
          if (valve_out !== e || k != 1 + j * 8) begin
            n_bad++;
            $display("FAIL %s step%0d: valve_out=%0d at k=%0d, want %0d at k=%0d",
                     nm, j, valve_out, k, e, 1 + j * 8);
          end
        end
        last = valve_out;
      end
      if (valve_valid === 1'b1) begin
        seen = 1'b1;
        n_cmp++;
        if (k != lat || valve_out !== tgt || exp_q.size() != 0) begin
          n_bad++;
          $display("FAIL %s done: k=%0d valve_out=%0d left=%0d, want k=%0d valve_out=%0d left=0",
                   nm, k, valve_out, exp_q.size(), lat, tgt);
        end
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: no valve_valid within %0d cycles, want at %0d", nm, lat + 20, lat);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (valve_valid !== 1'b0 || load_ready !== 1'b1 || addr_err !== m_err) begin
      n_bad++;
      $display("FAIL %s post: valve_valid=%b load_ready=%b addr_err=%b, want 0/1/%b",
               nm, valve_valid, load_ready, addr_err, m_err);
    end
    m_valve = tgt;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if (valve_out !== 6'd0 || busy !== 1'b0 || valve_valid !== 1'b0 || addr_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_in: valve_out=%0d busy=%b valid=%b err=%b, want 0/0/0/0",
               valve_out, busy, valve_valid, addr_err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (load_ready !== 1'b1 || busy !== 1'b0 || valve_out !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_out: load_ready=%b busy=%b valve_out=%0d, want 1/0/0",
               load_ready, busy, valve_out);
    end
  endtask

  task automatic test_unwritten;
    run_lookup(9'o111, 1'b0, "unwritten");
  endtask

  task automatic test_slew_up;
    load(9'o123, 6'd20);
    run_lookup(9'o123, 1'b0, "slew_up");
  endtask

  task automatic test_slew_down;
    load(9'o321, 6'd18);
    run_lookup(9'o321, 1'b0, "slew_down");
  endtask

  task automatic test_malformed;
    load(9'o041, 6'd30);
    run_lookup(9'o041, 1'b0, "bad_field_gt3");
    run_lookup(9'o101, 1'b0, "bad_field_zero");
  endtask

  task automatic test_priority;
    @(negedge clk);
    load_en = 1'b1; load_addr = 9'o222; load_data = 6'd33;
    addr_valid = 1'b1; addr_in = 9'o222;
    @(posedge clk); #1;
    load_en = 1'b0; addr_valid = 1'b0;
    m_mem[9'o222] = 6'd33; m_wr[9'o222] = 1'b1;
    n_cmp++;
    if (busy !== 1'b0 || load_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL priority: busy=%b load_ready=%b, want 0/1", busy, load_ready);
    end
    run_lookup(9'o222, 1'b1, "priority_then_lookup");
  endtask

  task automatic test_reset_mid_slew;
    bit pulsed;
    load(9'o333, 6'd63);
    @(negedge clk);
    addr_in = 9'o333; addr_valid = 1'b1;
    @(posedge clk); #1;
    addr_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if (valve_out !== m_valve + 6'd4) begin
      n_bad++;
      $display("FAIL mid_slew: valve_out=%0d, want %0d", valve_out, m_valve + 6'd4);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (valve_out !== 6'd0 || busy !== 1'b0 || addr_err !== 1'b0 || valve_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: valve_out=%0d busy=%b err=%b valid=%b, want 0/0/0/0",
               valve_out, busy, addr_err, valve_valid);
    end
    pulsed = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (valve_valid !== 1'b0) pulsed = 1'b1;
    end
    n_cmp++;
    if (pulsed) begin
      n_bad++;
      $display("FAIL reset_no_valid: valve_valid seen=1, want 0");
    end
    @(negedge clk); rst_n = 1'b1;
    m_valve = 6'd0; m_err = 1'b0;
    foreach (m_wr[i]) m_wr[i] = 1'b0;
    run_lookup(9'o123, 1'b0, "after_reset_123");
    run_lookup(9'o333, 1'b0, "after_reset_333");
  endtask

  initial begin
    foreach (m_wr[i]) m_wr[i] = 1'b0;
    test_reset();
    test_unwritten();
    test_slew_up();
    test_slew_down();
    test_malformed();
    test_priority();
    test_reset_mid_slew();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
